// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: tag store, age-based LRU tracker and read-miss fill sequencer
// for a 4-way fully associative, write-through, no-write-allocate cache.
module cache_tag_ctrl #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned OFFSET_W = 4
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] read_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic              mem_data_ready_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              read_hit_o,
  output logic              read_miss_o,
  output logic [1:0]        read_hit_way_o,
  output logic              write_hit_o,
  output logic [1:0]        write_hit_way_o,
  output logic [1:0]        lru_way_o,
  output logic              stall_o
);

  localparam int unsigned TAG_W  = ADDR_W - OFFSET_W;
  localparam int unsigned N_WAYS = 4;
  localparam int unsigned WAY_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_MISS_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Per-way storage; ages are kept as a permutation of 0..N_WAYS-1.
  logic [N_WAYS-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q [N_WAYS];
  logic [WAY_W-1:0]  age_q [N_WAYS];
  logic [WAY_W-1:0]  age_d [N_WAYS];

  // Miss context captured when leaving IDLE.
  logic [TAG_W-1:0]  ltag_q;
  logic [WAY_W-1:0]  vic_q;

  logic [TAG_W-1:0]  rd_tag;
  logic [TAG_W-1:0]  wr_tag;
  logic              rhit;
  logic              whit;
  logic [WAY_W-1:0]  rway;
  logic [WAY_W-1:0]  wway;
  logic [WAY_W-1:0]  vic_c;
  logic              latch_miss;
  logic              fill;
  logic              upd;
  logic [WAY_W-1:0]  upd_way;

  // Offset bits never take part in tag matching.
  logic unused_offsets;
  assign unused_offsets = ^{read_addr_i[OFFSET_W-1:0], write_addr_i[OFFSET_W-1:0]};

  assign rd_tag = read_addr_i[ADDR_W-1:OFFSET_W];
  assign wr_tag = write_addr_i[ADDR_W-1:OFFSET_W];

  // Tag lookup for both request ports; at most one way can match.
  always_comb begin
    rhit = 1'b0;
    whit = 1'b0;
    rway = '0;
    wway = '0;
    for (int i = 0; i < int'(N_WAYS); i++) begin
      if (valid_q[i] && (tag_q[i] == rd_tag)) begin
        rhit = 1'b1;
        rway = WAY_W'(i);
      end
      if (valid_q[i] && (tag_q[i] == wr_tag)) begin
        whit = 1'b1;
        wway = WAY_W'(i);
      end
    end
  end

  assign read_hit_o      = rd_en_i & rhit;
  assign read_miss_o     = rd_en_i & ~rhit;
  assign read_hit_way_o  = rway;
  assign write_hit_o     = wr_en_i & whit;
  assign write_hit_way_o = wway;

  // Victim: lowest invalid way if any, otherwise the oldest way.
  always_comb begin
    vic_c = '0;
    for (int i = 0; i < int'(N_WAYS); i++) begin
      if (age_q[i] == WAY_W'(N_WAYS - 1)) begin
        vic_c = WAY_W'(i);
      end
    end
    // Descending scan so the lowest invalid index is the last one written.
    for (int i = int'(N_WAYS) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        vic_c = WAY_W'(i);
      end
    end
  end

  // Next-state and miss-controller outputs.
  always_comb begin
    state_d    = state_q;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    stall_o    = 1'b0;
    lru_way_o  = vic_c;
    latch_miss = 1'b0;
    fill       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall_o = read_miss_o;
        if (read_miss_o) begin
          latch_miss = 1'b1;
          state_d    = ST_MISS_WAIT;
        end
      end
      ST_MISS_WAIT: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {ltag_q, OFFSET_W'(0)};
        stall_o    = 1'b1;
        lru_way_o  = vic_q;
        if (mem_data_ready_i) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single LRU touch per cycle: fill beats read hit beats store hit.
  always_comb begin
    upd     = 1'b1;
    upd_way = '0;
    if (fill) begin
      upd_way = vic_q;
    end else if (read_hit_o) begin
      upd_way = rway;
    end else if (write_hit_o) begin
      upd_way = wway;
    end else begin
      upd = 1'b0;
    end
  end

  // Ages younger than the touched way slide back by one; touched way becomes MRU.
  always_comb begin
    for (int j = 0; j < int'(N_WAYS); j++) begin
      age_d[j] = age_q[j];
      if (upd) begin
        if (WAY_W'(j) == upd_way) begin
          age_d[j] = '0;
        end else if (age_q[j] < age_q[upd_way]) begin
          age_d[j] = age_q[j] + WAY_W'(1);
        end
      end
    end
  end

  // State, tag store and miss context registers.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      ltag_q  <= '0;
      vic_q   <= '0;
      for (int i = 0; i < int'(N_WAYS); i++) begin
        tag_q[i] <= '0;
        age_q[i] <= WAY_W'(i);
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < int'(N_WAYS); i++) begin
        age_q[i] <= age_d[i];
      end
      if (latch_miss) begin
        ltag_q <= rd_tag;
        vic_q  <= vic_c;
      end
      if (fill) begin
        valid_q[vic_q] <= 1'b1;
        tag_q[vic_q]   <= ltag_q;
      end
    end
  end

endmodule
